// File: rtl/garage_door_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : garage_door_model_if
//  Description : Motor-command / limit-switch bundle between the garage door
//                controller (master) and the door plant model (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface garage_door_model_if #(
    parameter int PW = 8
);
    logic          UP_M;
    logic          DN_M;
    logic          clr_fault;
    logic          UP_Max;
    logic          DN_Max;
    logic [PW-1:0] position;
    logic          moving;
    logic          fault;

    // Controller side: issues motor commands, watches the limit switches.
    modport master (
        output UP_M, DN_M, clr_fault,
        input  UP_Max, DN_Max, position, moving, fault
    );

    // Plant side: consumes motor commands, reports door state.
    modport slave (
        input  UP_M, DN_M, clr_fault,
        output UP_Max, DN_Max, position, moving, fault
    );
endinterface
`default_nettype wire

// File: rtl/garage_door_model.sv
`default_nettype none
// ============================================================================
//  Module      : garage_door_model
//  Description : Behavioural door/motor plant. Moves a position counter one
//                step every STEP_DIV cycles under UP_M/DN_M, decodes the
//                limit switches and latches illegal command combinations.
//  Revision    : 1.0  initial release
// ============================================================================
module garage_door_model #(
    parameter int TRAVEL   = 100,
    parameter int STEP_DIV = 4,
    parameter int PW       = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    garage_door_model_if.slave    bus
);

    localparam int            PSW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] TRAVEL_P = PW'(TRAVEL);
    localparam logic [PSW-1:0] PRE_LAST = PSW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RISING  = 2'd1,
        ST_FALLING = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_position;
    logic [PW-1:0]  w_position_nxt;
    logic [PSW-1:0] r_presc;
    logic [PSW-1:0] w_presc_nxt;

    logic w_up;
    logic w_dn;
    logic w_both;

    assign w_up   = bus.UP_M;
    assign w_dn   = bus.DN_M;
    assign w_both = bus.UP_M & bus.DN_M;

    // State, position and prescaler registers; reset returns the door to closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_STOPPED;
            r_position <= '0;
            r_presc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_position <= w_position_nxt;
            r_presc    <= w_presc_nxt;
        end
    end

    // Next-state logic: command priority is fault, then stop, then step.
    always_comb begin
        w_state_nxt    = r_state;
        w_position_nxt = r_position;
        w_presc_nxt    = r_presc;
        case (r_state)
            ST_STOPPED: begin
                if (w_both) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_up && (r_position < TRAVEL_P)) begin
                    w_state_nxt = ST_RISING;
                    w_presc_nxt = '0;
                end else if (w_dn && (r_position != '0)) begin
                    w_state_nxt = ST_FALLING;
                    w_presc_nxt = '0;
                end
            end
            ST_RISING: begin
                if (w_both) begin
                    w_state_nxt = ST_FAULT;
                end else if (!w_up) begin
                    w_state_nxt = ST_STOPPED;
                    w_presc_nxt = '0;
                end else if (r_presc == PRE_LAST) begin
                    w_presc_nxt    = '0;
                    w_position_nxt = r_position + 1'b1;
                    // Stop on the same edge the upper limit is reached.
                    if ((r_position + 1'b1) == TRAVEL_P) begin
                        w_state_nxt = ST_STOPPED;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            ST_FALLING: begin
                if (w_both) begin
                    w_state_nxt = ST_FAULT;
                end else if (!w_dn) begin
                    w_state_nxt = ST_STOPPED;
                    w_presc_nxt = '0;
                end else if (r_presc == PRE_LAST) begin
                    w_presc_nxt    = '0;
                    w_position_nxt = r_position - 1'b1;
                    // Stop on the same edge the lower limit is reached.
                    if (r_position == PW'(1)) begin
                        w_state_nxt = ST_STOPPED;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            ST_FAULT: begin
                // Clearing is refused while any command is still asserted.
                if (bus.clr_fault && !w_up && !w_dn) begin
                    w_state_nxt = ST_STOPPED;
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
            end
        endcase
    end

    assign bus.position = r_position;
    assign bus.UP_Max   = (r_position == TRAVEL_P);
    assign bus.DN_Max   = (r_position == '0);
    assign bus.moving   = (r_state == ST_RISING) || (r_state == ST_FALLING);
    assign bus.fault    = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_garage_door_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_garage_door_model
//  Description : Directed self-checking bench for garage_door_model with
//                TRAVEL=10, STEP_DIV=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_garage_door_model;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    garage_door_model_if #(.PW(8)) bus ();

    garage_door_model #(
        .TRAVEL   (10),
        .STEP_DIV (4),
        .PW       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        bus.UP_M      = 1'b0;
        bus.DN_M      = 1'b0;
        bus.clr_fault = 1'b0;
        rst           = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.position !== 8'd0 || bus.DN_Max !== 1'b1 || bus.UP_Max !== 1'b0 ||
            bus.moving !== 1'b0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pos=%0d dn=%b up=%b mv=%b flt=%b, expected pos=0 dn=1 up=0 mv=0 flt=0",
                     bus.position, bus.DN_Max, bus.UP_Max, bus.moving, bus.fault);
        end
    endtask

    task automatic test_up_run();
        logic [7:0] exp_pos;
        bus.UP_M = 1'b1;
        tick();   // entry into RISING
        vectors++;
        if (bus.moving !== 1'b1 || bus.position !== 8'd0 || bus.DN_Max !== 1'b1) begin
            errors++;
            $display("FAIL up_entry: got mv=%b pos=%0d dn=%b, expected mv=1 pos=0 dn=1",
                     bus.moving, bus.position, bus.DN_Max);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_pos = 8'(i / 4);
            vectors++;
            if (bus.position !== exp_pos || bus.moving !== (i < 40) ||
                bus.DN_Max !== (exp_pos == 8'd0) || bus.UP_Max !== (exp_pos == 8'd10)) begin
                errors++;
                $display("FAIL up_run[%0d]: got pos=%0d mv=%b dn=%b up=%b, expected pos=%0d mv=%b",
                         i, bus.position, bus.moving, bus.DN_Max, bus.UP_Max, exp_pos, (i < 40));
            end
        end
        ticks(3);
        vectors++;
        if (bus.position !== 8'd10 || bus.UP_Max !== 1'b1 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL up_saturate: got pos=%0d up=%b mv=%b, expected pos=10 up=1 mv=0",
                     bus.position, bus.UP_Max, bus.moving);
        end
    endtask

    task automatic test_down_run();
        logic [7:0] exp_pos;
        bus.UP_M = 1'b0;
        bus.DN_M = 1'b1;
        tick();   // entry into FALLING
        vectors++;
        if (bus.moving !== 1'b1 || bus.position !== 8'd10) begin
            errors++;
            $display("FAIL down_entry: got mv=%b pos=%0d, expected mv=1 pos=10",
                     bus.moving, bus.position);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_pos = 8'(10 - i / 4);
            vectors++;
            if (bus.position !== exp_pos || bus.moving !== (i < 40) ||
                bus.DN_Max !== (exp_pos == 8'd0) || bus.UP_Max !== (exp_pos == 8'd10)) begin
                errors++;
                $display("FAIL down_run[%0d]: got pos=%0d mv=%b dn=%b up=%b, expected pos=%0d mv=%b",
                         i, bus.position, bus.moving, bus.DN_Max, bus.UP_Max, exp_pos, (i < 40));
            end
        end
        ticks(2);
        vectors++;
        if (bus.position !== 8'd0 || bus.DN_Max !== 1'b1 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL down_saturate: got pos=%0d dn=%b mv=%b, expected pos=0 dn=1 mv=0",
                     bus.position, bus.DN_Max, bus.moving);
        end
        bus.DN_M = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        // Up a little so the fault is taken away from a limit.
        bus.UP_M = 1'b1;
        ticks(9);     // entry + 8 cycles -> position 2
        bus.UP_M = 1'b0;
        tick();
        vectors++;
        if (bus.position !== 8'd2 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL fault_setup: got pos=%0d mv=%b, expected pos=2 mv=0",
                     bus.position, bus.moving);
        end
        bus.UP_M = 1'b1;
        bus.DN_M = 1'b1;
        tick();
        bus.DN_M = 1'b0;   // UP_M still high
        vectors++;
        if (bus.fault !== 1'b1 || bus.position !== 8'd2 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL fault_enter: got flt=%b pos=%0d mv=%b, expected flt=1 pos=2 mv=0",
                     bus.fault, bus.position, bus.moving);
        end
        bus.clr_fault = 1'b1;
        ticks(6);
        vectors++;
        if (bus.fault !== 1'b1 || bus.position !== 8'd2) begin
            errors++;
            $display("FAIL fault_clr_blocked: got flt=%b pos=%0d, expected flt=1 pos=2",
                     bus.fault, bus.position);
        end
        bus.UP_M = 1'b0;
        tick();
        bus.clr_fault = 1'b0;
        vectors++;
        if (bus.fault !== 1'b0 || bus.moving !== 1'b0 || bus.position !== 8'd2) begin
            errors++;
            $display("FAIL fault_clear: got flt=%b mv=%b pos=%0d, expected flt=0 mv=0 pos=2",
                     bus.fault, bus.moving, bus.position);
        end
    endtask

    task automatic test_limit_ignore();
        do_reset();
        bus.DN_M = 1'b1;
        ticks(3);
        vectors++;
        if (bus.moving !== 1'b0 || bus.position !== 8'd0 || bus.DN_Max !== 1'b1) begin
            errors++;
            $display("FAIL limit_ignore: got mv=%b pos=%0d dn=%b, expected mv=0 pos=0 dn=1",
                     bus.moving, bus.position, bus.DN_Max);
        end
        bus.DN_M = 1'b0;
        tick();
    endtask

    task automatic test_mid_stop();
        do_reset();
        bus.UP_M = 1'b1;
        ticks(21);    // entry + 20 cycles -> position 5
        bus.UP_M = 1'b0;
        ticks(3);
        vectors++;
        if (bus.position !== 8'd5 || bus.UP_Max !== 1'b0 || bus.DN_Max !== 1'b0 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL mid_stop: got pos=%0d up=%b dn=%b mv=%b, expected pos=5 up=0 dn=0 mv=0",
                     bus.position, bus.UP_Max, bus.DN_Max, bus.moving);
        end
        bus.UP_M = 1'b1;
        ticks(4);     // re-entry + 3 cycles: not yet stepped
        vectors++;
        if (bus.position !== 8'd5 || bus.moving !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart_early: got pos=%0d mv=%b, expected pos=5 mv=1",
                     bus.position, bus.moving);
        end
        tick();
        vectors++;
        if (bus.position !== 8'd6) begin
            errors++;
            $display("FAIL mid_restart_step: got pos=%0d, expected pos=6", bus.position);
        end
        bus.UP_M = 1'b0;
        tick();
    endtask

    task automatic test_reversal();
        do_reset();
        bus.UP_M = 1'b1;
        ticks(13);    // entry + 12 cycles -> position 3
        bus.UP_M = 1'b0;
        bus.DN_M = 1'b1;
        tick();
        vectors++;
        if (bus.moving !== 1'b0 || bus.position !== 8'd3) begin
            errors++;
            $display("FAIL reversal_gap: got mv=%b pos=%0d, expected mv=0 pos=3",
                     bus.moving, bus.position);
        end
        tick();
        vectors++;
        if (bus.moving !== 1'b1 || bus.position !== 8'd3) begin
            errors++;
            $display("FAIL reversal_fall: got mv=%b pos=%0d, expected mv=1 pos=3",
                     bus.moving, bus.position);
        end
        ticks(3);
        vectors++;
        if (bus.position !== 8'd3) begin
            errors++;
            $display("FAIL reversal_early: got pos=%0d, expected pos=3", bus.position);
        end
        tick();
        vectors++;
        if (bus.position !== 8'd2) begin
            errors++;
            $display("FAIL reversal_step: got pos=%0d, expected pos=2", bus.position);
        end
        bus.DN_M = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.UP_M = 1'b1;
        ticks(29);    // entry + 28 cycles -> position 7
        vectors++;
        if (bus.position !== 8'd7 || bus.moving !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: got pos=%0d mv=%b, expected pos=7 mv=1",
                     bus.position, bus.moving);
        end
        #2;
        rst = 1'b0;
        #1;           // well before the next rising edge
        vectors++;
        if (bus.position !== 8'd0 || bus.DN_Max !== 1'b1 || bus.moving !== 1'b0 || bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pos=%0d dn=%b mv=%b flt=%b, expected pos=0 dn=1 mv=0 flt=0",
                     bus.position, bus.DN_Max, bus.moving, bus.fault);
        end
        bus.UP_M = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        vectors       = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.UP_M      = 1'b0;
        bus.DN_M      = 1'b0;
        bus.clr_fault = 1'b0;
        test_reset();
        test_up_run();
        test_down_run();
        test_fault();
        test_limit_ignore();
        test_mid_stop();
        test_reversal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/garage_door_model.md
Name: garage_door_model

Overview:
Behavioural door/motor plant that sits at the far end of the garage controller's motor interface. It consumes the UP_M/DN_M motor commands, moves a door-position counter at a fixed step rate, and produces the UP_Max/DN_Max limit-switch signals that close the control loop. It also detects illegal command combinations. It is used as the closed-loop partner of the controller in system simulation and on FPGA demo builds.

Parameters:
TRAVEL, 100, number of position steps from fully closed (0) to fully open (TRAVEL); must be at least 1.
STEP_DIV, 4, number of clk cycles per position step while moving; must be at least 1.
PW, 8, width of the position output; must be at least clog2(TRAVEL+1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
UP_M  input  1  motor-up command.
DN_M  input  1  motor-down command.
clr_fault  input  1  fault clear request (level).
UP_Max  output  1  upper limit switch: door fully open.
DN_Max  output  1  lower limit switch: door fully closed.
position  output  PW  current door position, 0 = closed.
moving  output  1  door is in motion.
fault  output  1  illegal command detected; latched.

Behaviour:
- Reset: the clock is clk; the reset is rst, asynchronous, active-low. While rst=0 the block holds: state=STOPPED, position=0, prescaler=0, DN_Max=1, UP_Max=0, moving=0, fault=0. This applies to reset asserted mid-travel as well; the model returns to closed.
- UP_Max = (position==TRAVEL) and DN_Max = (position==0). Both are decoded from the registered position, so they change on the same edge as position. They are never both 1 when TRAVEL is at least 1.
- moving = 1 in RISING or FALLING. fault = 1 in FAULT. Both are registered state decodes.
- States: STOPPED, RISING, FALLING, FAULT. Transitions are evaluated each rising edge, in priority order.
- STOPPED:
  - UP_M & DN_M -> FAULT.
  - UP_M & position<TRAVEL -> RISING.
  - DN_M & position>0 -> FALLING.
  - Otherwise stay.
  - A command toward an already-reached limit is ignored.
- RISING:
  - UP_M & DN_M -> FAULT.
  - !UP_M -> STOPPED; position holds, prescaler cleared.
  - Otherwise, the prescaler increments each cycle. When prescaler==STEP_DIV-1, position increments and the prescaler wraps to 0.
  - If that increment makes position==TRAVEL, go to STOPPED on the same edge.
- FALLING: mirror of RISING. Uses DN_M, decrements position, and stops on the edge where position becomes 0.
- FAULT:
  - Position and prescaler hold.
  - Exit to STOPPED only when clr_fault=1 and UP_M=0 and DN_M=0.
  - clr_fault while any command is high has no effect.
- Prescaler is cleared on every entry into RISING or FALLING.
- Timing: if a command is sampled at edge N in STOPPED, the state is RISING/FALLING after edge N. The first position step occurs at edge N+STEP_DIV.
- Full-travel latency: TRAVEL*STEP_DIV cycles of moving=1.
- Direction reversal: swapping UP_M->DN_M in one cycle passes through exactly one STOPPED cycle before FALLING. Position is not stepped during the STOPPED cycle.
- Position saturates: it never exceeds TRAVEL and never wraps below 0.

Test Plan:
1. Up run (TRAVEL=10, STEP_DIV=4). Reset, then hold UP_M=1.
   -> DN_Max=1 and position=0 at reset.
   -> DN_Max falls with the first step, 4 cycles after entering RISING.
   -> position reaches 10 after 40 moving cycles; UP_Max=1, moving=0 on that edge.
   -> Continued UP_M keeps position at 10.
2. Down run: from position 10, hold DN_M=1.
   -> position decrements every 4 cycles.
   -> position=0 and DN_Max=1 after 40 cycles; moving=0.
3. Fault handling: in STOPPED, drive UP_M=DN_M=1 for 1 cycle.
   -> fault=1 next cycle, position unchanged.
   -> clr_fault=1 with UP_M=1: fault stays 1.
   -> clr_fault=1 with both commands 0: fault=0, state STOPPED.
4. Mid-travel stop: rising, drop UP_M at position=5.
   -> position holds 5, UP_Max=0, DN_Max=0, moving=0.
   -> Reasserting UP_M gives position 6 exactly 4 cycles after re-entry.
5. Reversal: rising at position 3, swap to DN_M in one cycle.
   -> one cycle with moving=0, then FALLING.
   -> position=2 four cycles after entering FALLING.
6. Async reset: assert rst=0 mid-cycle at position 7 while rising.
   -> position=0, DN_Max=1, moving=0, fault=0 immediately, without waiting for a clk edge.
